// File: rtl/fme_pkg.sv
// Shared constants for the FME half-pel path.
// Tap count, default block geometry and counter widths.
package fme_pkg;

  localparam int PIX_W      = 8;
  localparam int TAP_N      = 6;
  localparam int ROW_LEN_D  = 21;
  localparam int NUM_ROWS_D = 21;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W = cw(ROW_LEN_D);
  localparam int ROW_W = cw(NUM_ROWS_D);

endpackage

// File: rtl/fme_pos_counter.sv
// Column/row position tracking for the tap window feeder.
// Handles wrap, sof resync and last/err decode.
module fme_pos_counter #(
  parameter int ROW_LEN  = 21,
  parameter int NUM_ROWS = 21,
  parameter int COL_W    = 5,
  parameter int ROW_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc,
  input  logic             sof,
  output logic             emit,
  output logic [COL_W-1:0] tag_col,
  output logic [ROW_W-1:0] tag_row,
  output logic             last,
  output logic             err
);
  import fme_pkg::*;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(ROW_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] FIRST   = COL_W'(TAP_N - 1);

  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
      err_q   <= 1'b0;
    end else if (acc) begin
      if (sof) begin
        // sof pixel is col 0, so the next one is col 1
        col_cnt <= COL_W'(1);
        row_cnt <= '0;
        if (col_cnt != '0 || row_cnt != '0)
          err_q <= 1'b1;
      end else if (col_cnt == COL_MAX) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_MAX) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  assign emit    = acc && !sof && (col_cnt >= FIRST);
  assign tag_col = col_cnt - FIRST;
  assign tag_row = row_cnt;
  assign last    = (col_cnt == COL_MAX) && (row_cnt == ROW_MAX);
  assign err     = err_q;

endmodule

// File: rtl/fme_tap_window.sv
// Six-tap horizontal window feeder for the half-pel filter.
// Shift register plus valid/ready handshake; positions in fme_pos_counter.
module fme_tap_window #(
  parameter  int PIX_W    = fme_pkg::PIX_W,
  parameter  int ROW_LEN  = fme_pkg::ROW_LEN_D,
  parameter  int NUM_ROWS = fme_pkg::NUM_ROWS_D,
  localparam int COL_W    = fme_pkg::cw(ROW_LEN),
  localparam int ROW_W    = fme_pkg::cw(NUM_ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_a,
  output logic [PIX_W-1:0] out_b,
  output logic [PIX_W-1:0] out_c,
  output logic [PIX_W-1:0] out_d,
  output logic [PIX_W-1:0] out_e,
  output logic [PIX_W-1:0] out_f,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             out_last,
  output logic             sof_err
);
  import fme_pkg::TAP_N;

  logic [PIX_W-1:0] taps [TAP_N];
  logic             acc;
  logic             emit;
  logic             last_d;
  logic [COL_W-1:0] col_d;
  logic [ROW_W-1:0] row_d;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  fme_pos_counter #(
    .ROW_LEN  (ROW_LEN),
    .NUM_ROWS (NUM_ROWS),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc     (acc),
    .sof     (in_sof),
    .emit    (emit),
    .tag_col (col_d),
    .tag_row (row_d),
    .last    (last_d),
    .err     (sof_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAP_N; i++)
        taps[i] <= '0;
    end else if (acc) begin
      for (int i = 0; i < TAP_N - 1; i++)
        taps[i] <= taps[i+1];
      taps[TAP_N-1] <= in_pix;
    end
  end

  // an emitting accept overrides a same-cycle drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_col   <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (emit)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
      if (emit) begin
        out_col  <= col_d;
        out_row  <= row_d;
        out_last <= last_d;
      end
    end
  end

  assign out_a = taps[0];
  assign out_b = taps[1];
  assign out_c = taps[2];
  assign out_d = taps[3];
  assign out_e = taps[4];
  assign out_f = taps[5];

endmodule

// File: tb/tb_fme_tap_window.sv
// Self-checking bench for fme_tap_window: row-buffer model,
// per-cycle scoreboard and directed literal checks.
module tb_fme_tap_window;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_pix = 8'd0;
  logic       in_ready, out_valid, out_last, sof_err;
  logic [7:0] out_a, out_b, out_c, out_d, out_e, out_f;
  logic [4:0] out_col, out_row;

  always #5 clk = ~clk;

  fme_tap_window dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_col   (out_col),
    .out_row   (out_row),
    .out_last  (out_last),
    .sof_err   (sof_err)
  );

  typedef struct packed {
    logic [7:0] a, b, c, d, e, f;
    logic [4:0] col, row;
    logic       last;
  } win_t;

  win_t       expq[$];
  win_t       got[$];
  int         checks = 0;
  int         failures = 0;
  int         mcol = 0;
  int         mrow = 0;
  logic [7:0] rowbuf [21];
  bit         exp_err = 1'b0;
  bit         rnd_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: pixels land in a row buffer at their column
  always @(negedge clk) begin
    win_t w, e;
    if (!rst_n) begin
      expq.delete();
      mcol = 0;
      mrow = 0;
      exp_err = 1'b0;
    end else begin
      chk("out_valid", out_valid, expq.size() > 0);
      chk("sof_err", sof_err, exp_err);
      if (out_valid && out_ready) begin
        w = {out_a, out_b, out_c, out_d, out_e, out_f,
             out_col, out_row, out_last};
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL window: got %h expected none", w);
        end else begin
          e = expq.pop_front();
          if (w != e) begin
            failures++;
            $display("FAIL window: got %h expected %h at %0t", w, e, $time);
          end
        end
        got.push_back(w);
      end
      if (in_valid && in_ready) begin
        if (in_sof) begin
          if (mcol != 0 || mrow != 0) exp_err = 1'b1;
          mcol = 0;
          mrow = 0;
        end
        rowbuf[mcol] = in_pix;
        if (!in_sof && mcol >= 5) begin
          e.a = rowbuf[mcol-5];
          e.b = rowbuf[mcol-4];
          e.c = rowbuf[mcol-3];
          e.d = rowbuf[mcol-2];
          e.e = rowbuf[mcol-1];
          e.f = rowbuf[mcol];
          e.col = 5'(mcol - 5);
          e.row = 5'(mrow);
          e.last = (mcol == 20 && mrow == 20);
          expq.push_back(e);
        end
        mcol++;
        if (mcol == 21) begin
          mcol = 0;
          mrow = (mrow + 1) % 21;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] p, input bit sof, input bit rnd);
    int n;
    if (rnd) begin
      n = $urandom_range(0, 3);
      if (n > 1) idle(n - 1);
    end
    in_valid = 1'b1;
    in_pix = p;
    in_sof = sof;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready 0 expected 1 pix %0d", p);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  initial begin
    int nlast, nbad;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_last", out_last, 0);
    idle(1);

    // 1: single row
    got.delete();
    for (int i = 0; i < 21; i++) send(8'(i), i == 0, 1'b0);
    idle(2);
    chk("t1_count", got.size(), 16);
    chk("t1_first_a", got[0].a, 0);
    chk("t1_first_f", got[0].f, 5);
    chk("t1_first_col", got[0].col, 0);
    chk("t1_last_a", got[15].a, 15);
    chk("t1_last_f", got[15].f, 20);
    chk("t1_last_col", got[15].col, 15);

    // 2: full block
    do_reset();
    got.delete();
    for (int i = 0; i < 441; i++) send(8'(i), i == 0, 1'b0);
    idle(2);
    chk("t2_count", got.size(), 336);
    nlast = 0;
    nbad = 0;
    foreach (got[k]) begin
      if (got[k].last) nlast++;
      if (got[k].a == 8'd16 && got[k].f == 8'd21) nbad++;
    end
    chk("t2_nlast", nlast, 1);
    chk("t2_straddle", nbad, 0);
    chk("t2_end_last", got[335].last, 1);
    chk("t2_end_row", got[335].row, 20);
    chk("t2_end_col", got[335].col, 15);
    chk("t2_end_a", got[335].a, 179);
    chk("t2_end_f", got[335].f, 184);

    // 3: backpressure mid-row
    got.delete();
    for (int i = 0; i < 10; i++) send(8'(50 + i), i == 0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_pix = 8'd60;
    repeat (4) begin
      @(negedge clk);
      chk("t3_in_ready", in_ready, 0);
      chk("t3_valid", out_valid, 1);
      chk("t3_frozen_f", out_f, 59);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 10; i < 21; i++) send(8'(50 + i), 1'b0, 1'b0);
    idle(2);
    chk("t3_count", got.size(), 16);
    foreach (got[k]) chk("t3_seq_f", got[k].f, 55 + k);

    // 4: random handshakes, three blocks
    do_reset();
    got.delete();
    rnd_en = 1'b1;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 441; i++) send(8'(i * 7 + b), i == 0, 1'b1);
    rnd_en = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(3);
    nlast = 0;
    foreach (got[k]) if (got[k].last) nlast++;
    chk("t4_count", got.size(), 1008);
    chk("t4_nlast", nlast, 3);
    chk("t4_sof_err", sof_err, 0);

    // 5: sof off boundary at row 3 col 7
    do_reset();
    got.delete();
    for (int i = 0; i < 70; i++) send(8'(i), i == 0, 1'b0);
    send(8'd200, 1'b1, 1'b0);
    for (int i = 1; i < 6; i++) send(8'(200 + i), 1'b0, 1'b0);
    idle(2);
    chk("t5_sof_err", sof_err, 1);
    chk("t5_count", got.size(), 51);
    chk("t5_pre_col", got[49].col, 1);
    chk("t5_pre_row", got[49].row, 3);
    chk("t5_pre_f", got[49].f, 69);
    chk("t5_new_col", got[50].col, 0);
    chk("t5_new_row", got[50].row, 0);
    chk("t5_new_a", got[50].a, 200);
    chk("t5_new_f", got[50].f, 205);

    // 6: reset mid-row 10 with a pending window
    do_reset();
    got.delete();
    for (int i = 0; i < 218; i++) send(8'(i), i == 0, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("t6_pre_valid", out_valid, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_col", out_col, 0);
    chk("t6_rst_row", out_row, 0);
    chk("t6_rst_f", out_f, 0);
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 21; i++) send(8'(30 + i), 1'b0, 1'b0);
    idle(2);
    chk("t6_count", got.size(), 16);
    chk("t6_first_a", got[0].a, 30);
    chk("t6_first_col", got[0].col, 0);
    chk("t6_first_row", got[0].row, 0);
    chk("t6_last_f", got[15].f, 50);
    chk("t6_sof_err", sof_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
